uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial-to-parallel UART receiver; the receiving end of the link driven by the team's UART transmitter.
- Frame format: 8N1, i.e. one start bit (0), 8 data bits LSB first, one stop bit (1). Idle line is 1.
- Samples the asynchronous serial input at mid-bit using a per-bit clock counter.
- Presents each received byte on a holding register with a ready/read handshake, plus framing-error and overrun reporting.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit. Legal range is 4 and up; values below 4 are illegal.
- SYNC_STAGES, 2, number of input synchronizer flops. Legal range is 2 and up.

Ports:
- clk  input  1  system clock; all logic runs on the rising edge.
- reset  input  1  reset is synchronous and active-high.
- rx_data  input  1  asynchronous serial line.
- read_data  input  1  one-cycle pulse from the consumer; acknowledges and consumes data_out.
- data_out  output  8  last good received byte.
- data_ready  output  1  level; high while data_out holds an unread byte.
- framing_error  output  1  one-cycle pulse when the stop bit is sampled as 0.
- overrun  output  1  sticky; a byte was overwritten before it was read.
- rx_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (sampled at a clk edge): FSM goes to IDLE and all synchronizer flops load 1. Output values after reset: data_out=0x00, data_ready=0, framing_error=0, overrun=0, rx_busy=0. Reset mid-frame abandons the frame with no outputs produced.
- Synchronizer: rx_data passes through SYNC_STAGES flops to give rx_s. rx_s_d is rx_s delayed by one cycle. Nothing else reads rx_data directly.
- Bit timer: counter sized clog2(CLKS_PER_BIT)+1 bits. Reloads to 0 on every state entry.
- Bit index: 3-bit counter over data bits 0..7.
- FSM states:
  - IDLE: stays in IDLE until rx_s=0 and rx_s_d=1 (falling edge); call that cycle t0. Then goes to START with the timer cleared.
  - START: samples rx_s when timer = CLKS_PER_BIT/2 - 1, i.e. cycle t0+CLKS_PER_BIT/2 (integer division). If the sample is 1, it is a false start: go to IDLE with no outputs. If 0, go to DATA with bit index 0.
  - DATA: samples rx_s every CLKS_PER_BIT cycles. Bit k is sampled at t0+CLKS_PER_BIT/2+(k+1)*CLKS_PER_BIT and shifted into a shadow register LSB first. After bit 7, go to STOP.
  - STOP: samples at t0+CLKS_PER_BIT/2+9*CLKS_PER_BIT.
    - Sample 1: the shadow byte is loaded into data_out and data_ready is set.
    - Sample 0: framing_error pulses high for exactly one cycle; data_out and data_ready are unchanged and the byte is discarded.
    - Either way, the FSM goes to IDLE on the same edge. No wait for the end of the stop bit, so back-to-back frames are accepted.
- Latency: data_ready and the new data_out are visible in cycle t0+CLKS_PER_BIT/2+9*CLKS_PER_BIT+1. framing_error is visible in that same cycle.
- After a framing error, a new frame is only detected on a fresh 1-to-0 edge. A line held low (break) produces exactly one framing_error and then stays in IDLE.
- Handshake:
  - read_data with data_ready=1 clears data_ready and overrun on the next edge.
  - read_data with data_ready=0 is ignored.
- Good stop while data_ready=1 and no read_data in that cycle: data_out is overwritten, data_ready stays 1, and overrun is set. overrun stays set until read_data or reset.
- Good stop in the same cycle as read_data: the new byte loads, data_ready stays 1, and overrun is cleared, not set.
- rx_busy = (state != IDLE). It is registered together with the state.

Test Plan:
- CLKS_PER_BIT=16. Send 0xA5 with a good stop bit -> data_out=0xA5, data_ready=1 at t0+153, framing_error=0, overrun=0, rx_busy=0 from t0+153.
- Send a low glitch lasting 4 clk cycles -> rx_busy high for 8 cycles, then 0; data_ready stays 0; no framing_error.
- Send 0x3C with stop bit 0 -> single-cycle framing_error at t0+153; data_ready=0; data_out keeps its prior value. Then a line-high gap, then 0x81 -> data_out=0x81.
- Send 0x55 then 0xAA back-to-back with no read_data -> data_out=0xAA, data_ready=1, overrun=1. Pulse read_data -> data_ready=0 and overrun=0 next cycle.
- Pulse read_data in the exact completion cycle of a second byte 0x0F -> data_out=0x0F, data_ready=1, overrun=0.
- Assert reset during data bit 4 of 0xFF -> all outputs at reset values next cycle. A following frame 0x12 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, holding register with ready/read
// handshake, one-cycle framing-error pulse and sticky overrun flag.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_data,
    input  logic       read_data,
    output logic [7:0] data_out,
    output logic       data_ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_s_prev_q;
    logic [TW-1:0]          timer_q;
    logic [2:0]             bit_idx_q;
    logic [7:0]             shift_q;
    logic [7:0]             data_q;
    logic                   ready_q;
    logic                   ferr_q;
    logic                   overrun_q;
    logic                   busy_q;

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sync_q      <= '1;
            rx_s_prev_q <= 1'b1;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            ferr_q      <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], rx_data};
            rx_s_prev_q <= rx_s;
            ferr_q      <= 1'b0;
            timer_q     <= timer_q + 1'b1;

            if (read_data && ready_q) begin
                ready_q   <= 1'b0;
                overrun_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (!rx_s && rx_s_prev_q) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (timer_q == HALF_M1) begin
                        timer_q <= '0;
                        if (rx_s) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
                        end
                    end
                end
                DATA: begin
                    if (timer_q == FULL_M1) begin
                        timer_q <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) state_q <= STOP;
                        else bit_idx_q <= bit_idx_q + 3'd1;
                    end
                end
                STOP: begin
                    if (timer_q == FULL_M1) begin
                        timer_q <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (rx_s) begin
                            // Overrides the handshake clear above: a same-cycle read keeps the new byte ready.
                            data_q    <= shift_q;
                            ready_q   <= 1'b1;
                            overrun_q <= ready_q && !read_data;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out      = data_q;
    assign data_ready    = ready_q;
    assign framing_error = ferr_q;
    assign overrun       = overrun_q;
    assign rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_data;
    logic       read_data;
    logic [7:0] data_out;
    logic       data_ready;
    logic       framing_error;
    logic       overrun;
    logic       rx_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .read_data    (read_data),
        .data_out     (data_out),
        .data_ready   (data_ready),
        .framing_error(framing_error),
        .overrun      (overrun),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    // Start bit driven just after edge 0; with two sync stages t0 is cycle 2,
    // so results become visible in cycle 2+153 = 155. Returns in cycle 154.
    task automatic send_until_stop(input logic [7:0] b, input logic stop);
        rx_data = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx_data = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx_data = stop;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_until_stop(b, stop);
        repeat (6) @(posedge clk);
        #1;
        rx_data = 1'b1;
    endtask

    task automatic pulse_read();
        read_data = 1'b1;
        @(posedge clk);
        #1;
        read_data = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_data = 1'b1; read_data = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (data_out !== 8'h00) begin tests_failed++; $display("FAIL reset_data_out got %h exp 00", data_out); end
        tests_run++; if (data_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got %b exp 0", data_ready); end
        tests_run++; if (framing_error !== 1'b0) begin tests_failed++; $display("FAIL reset_ferr got %b exp 0", framing_error); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        tests_run++; if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", rx_busy); end
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_good_frame();
        send_until_stop(8'hA5, 1'b1);
        tests_run++; if (data_ready !== 1'b0) begin tests_failed++; $display("FAIL good_early_ready got %b exp 0", data_ready); end
        tests_run++; if (rx_busy !== 1'b1) begin tests_failed++; $display("FAIL good_early_busy got %b exp 1", rx_busy); end
        @(posedge clk); #1;
        tests_run++; if (data_out !== 8'hA5) begin tests_failed++; $display("FAIL good_data got %h exp a5", data_out); end
        tests_run++; if (data_ready !== 1'b1) begin tests_failed++; $display("FAIL good_ready got %b exp 1", data_ready); end
        tests_run++; if (framing_error !== 1'b0) begin tests_failed++; $display("FAIL good_ferr got %b exp 0", framing_error); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL good_overrun got %b exp 0", overrun); end
        tests_run++; if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL good_busy got %b exp 0", rx_busy); end
        repeat (5) @(posedge clk); #1;
        pulse_read();
        tests_run++; if (data_ready !== 1'b0) begin tests_failed++; $display("FAIL good_read_clear got %b exp 0", data_ready); end
        repeat (4) @(posedge clk); #1;
        pulse_read();
        tests_run++; if (data_ready !== 1'b0) begin tests_failed++; $display("FAIL idle_read_ignored got %b exp 0", data_ready); end
    endtask

    task automatic test_glitch();
        int busy_cnt = 0;
        int ferr_cnt = 0;
        logic busy_c3 = 1'b0;
        rx_data = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk); #1;
            if (n == 4) rx_data = 1'b1;
            if (rx_busy) busy_cnt++;
            if (framing_error) ferr_cnt++;
            if (n == 3) busy_c3 = rx_busy;
        end
        tests_run++; if (busy_cnt != 8) begin tests_failed++; $display("FAIL glitch_busy_cycles got %0d exp 8", busy_cnt); end
        tests_run++; if (busy_c3 !== 1'b1) begin tests_failed++; $display("FAIL glitch_busy_start got %b exp 1", busy_c3); end
        tests_run++; if (ferr_cnt != 0) begin tests_failed++; $display("FAIL glitch_ferr got %0d exp 0", ferr_cnt); end
        tests_run++; if (data_ready !== 1'b0) begin tests_failed++; $display("FAIL glitch_ready got %b exp 0", data_ready); end
    endtask

    task automatic test_framing();
        send_until_stop(8'h3C, 1'b0);
        tests_run++; if (framing_error !== 1'b0) begin tests_failed++; $display("FAIL ferr_early got %b exp 0", framing_error); end
        @(posedge clk); #1;
        tests_run++; if (framing_error !== 1'b1) begin tests_failed++; $display("FAIL ferr_pulse got %b exp 1", framing_error); end
        tests_run++; if (data_ready !== 1'b0) begin tests_failed++; $display("FAIL ferr_ready got %b exp 0", data_ready); end
        tests_run++; if (data_out !== 8'hA5) begin tests_failed++; $display("FAIL ferr_data_kept got %h exp a5", data_out); end
        @(posedge clk); #1;
        tests_run++; if (framing_error !== 1'b0) begin tests_failed++; $display("FAIL ferr_width got %b exp 0", framing_error); end
        repeat (4) @(posedge clk); #1;
        rx_data = 1'b1;
        repeat (20) @(posedge clk); #1;
        send_frame(8'h81, 1'b1);
        tests_run++; if (data_out !== 8'h81) begin tests_failed++; $display("FAIL after_ferr_data got %h exp 81", data_out); end
        tests_run++; if (data_ready !== 1'b1) begin tests_failed++; $display("FAIL after_ferr_ready got %b exp 1", data_ready); end
        pulse_read();
        repeat (4) @(posedge clk); #1;
    endtask

    task automatic test_break();
        int ferr_cnt = 0;
        send_until_stop(8'h00, 1'b0);
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            if (framing_error) ferr_cnt++;
        end
        tests_run++; if (ferr_cnt != 1) begin tests_failed++; $display("FAIL break_ferr_count got %0d exp 1", ferr_cnt); end
        tests_run++; if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL break_busy got %b exp 0", rx_busy); end
        rx_data = 1'b1;
        repeat (8) @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        send_frame(8'h55, 1'b1);
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL b2b_first_overrun got %b exp 0", overrun); end
        send_frame(8'hAA, 1'b1);
        tests_run++; if (data_out !== 8'hAA) begin tests_failed++; $display("FAIL b2b_data got %h exp aa", data_out); end
        tests_run++; if (data_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready got %b exp 1", data_ready); end
        tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL b2b_overrun got %b exp 1", overrun); end
        repeat (3) @(posedge clk); #1;
        tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL b2b_overrun_sticky got %b exp 1", overrun); end
        pulse_read();
        tests_run++; if (data_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_read_ready got %b exp 0", data_ready); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL b2b_read_overrun got %b exp 0", overrun); end
        repeat (4) @(posedge clk); #1;
    endtask

    task automatic test_read_collision();
        send_frame(8'h33, 1'b1);
        send_until_stop(8'h0F, 1'b1);
        read_data = 1'b1;
        @(posedge clk); #1;
        read_data = 1'b0;
        tests_run++; if (data_out !== 8'h0F) begin tests_failed++; $display("FAIL coll_data got %h exp 0f", data_out); end
        tests_run++; if (data_ready !== 1'b1) begin tests_failed++; $display("FAIL coll_ready got %b exp 1", data_ready); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL coll_overrun got %b exp 0", overrun); end
        repeat (5) @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame();
        rx_data = 1'b0;
        repeat (CPB) @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            rx_data = 1'b1;
            repeat (CPB) @(posedge clk); #1;
        end
        rx_data = 1'b1;
        repeat (CPB / 2) @(posedge clk); #1;
        tests_run++; if (rx_busy !== 1'b1) begin tests_failed++; $display("FAIL mid_busy_before got %b exp 1", rx_busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (data_out !== 8'h00) begin tests_failed++; $display("FAIL mid_reset_data got %h exp 00", data_out); end
        tests_run++; if (data_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_ready got %b exp 0", data_ready); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_overrun got %b exp 0", overrun); end
        tests_run++; if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_busy got %b exp 0", rx_busy); end
        tests_run++; if (framing_error !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_ferr got %b exp 0", framing_error); end
        reset = 1'b0;
        repeat (5 * CPB) @(posedge clk); #1;
        tests_run++; if (data_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_abandoned_ready got %b exp 0", data_ready); end
        send_frame(8'h12, 1'b1);
        tests_run++; if (data_out !== 8'h12) begin tests_failed++; $display("FAIL mid_next_data got %h exp 12", data_out); end
        tests_run++; if (data_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_next_ready got %b exp 1", data_ready); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL mid_next_overrun got %b exp 0", overrun); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_glitch();
        test_framing();
        test_break();
        test_back_to_back();
        test_read_collision();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
